// File: rtl/xcvr_csr_pkg.sv
// Shared definitions for the transceiver CSR agent: register map, response codes, FSM states
// and the response-pipe entry layout.
package xcvr_csr_pkg;

  localparam int unsigned AddrId       = 0;
  localparam int unsigned AddrScratch  = 1;
  localparam int unsigned AddrControl  = 2;
  localparam int unsigned AddrStatus   = 3;
  localparam int unsigned AddrCycles   = 4;
  localparam int unsigned AddrWrcount  = 5;
  localparam int unsigned AddrErrcount = 6;

  localparam logic [31:0] UnmappedData = 32'hDEAD_BEEF;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam int unsigned InitCycles = 4;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  resp;
    logic [31:0] data;
  } resp_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/xcvr_csr_resp_pipe.sv
// Fixed-depth shift pipe of response entries; an entry pushed at acceptance emerges Depth
// cycles later.
module xcvr_csr_resp_pipe
  import xcvr_csr_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  resp_entry_t entry_i,
  output resp_entry_t entry_o
);

  resp_entry_t stage_q [Depth];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign entry_o = stage_q[Depth-1];

endmodule

// File: rtl/xcvr_csr_agent.sv
// Avalon-MM CSR agent for the transceiver block: ID/scratch/control/status/counter registers.
// Optional write responses are enabled by defining XCVR_CSR_AGENT_WRITERESPONSE_EN.
module xcvr_csr_agent
  import xcvr_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned HDL_ADDR_WIDTH = 4,
  parameter int unsigned READ_LATENCY   = 2,
  parameter logic [31:0] ID_VALUE       = 32'hF7E1_0001
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      s0_waitrequest,
  output logic [DATA_WIDTH-1:0]     s0_readdata,
  output logic                      s0_readdatavalid,
  input  logic [DATA_WIDTH-1:0]     s0_writedata,
  input  logic [HDL_ADDR_WIDTH-1:0] s0_address,
  input  logic                      s0_write,
  input  logic                      s0_read,
  input  logic [3:0]                s0_byteenable,
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
  output logic                      s0_writeresponsevalid,
  output logic [1:0]                s0_response,
`endif
  input  logic [31:0]               status_in,
  output logic [7:0]                ctrl_out
);

  state_e      state_q;
  logic [1:0]  init_cnt_q;
  logic        waitrequest_q;

  logic [31:0] scratch_q;
  logic [7:0]  ctrl_q;
  logic [31:0] status_q;
  logic [31:0] cycles_q;
  logic [31:0] wrcount_q;
  logic [31:0] errcount_q;

  logic        rd_acc, wr_acc, collide, wr_do, mapped, err_evt;
  logic [31:0] addr_idx;
  logic [31:0] rd_data;
  resp_entry_t pipe_in, pipe_out;

  // Bring-up FSM: hold off the host for a fixed number of cycles after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      waitrequest_q <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 2'd1;
          if (init_cnt_q == 2'(InitCycles - 1)) begin
            state_q       <= StReady;
            waitrequest_q <= 1'b0;
          end
        end
        StReady: waitrequest_q <= 1'b0;
      endcase
    end
  end

  assign s0_waitrequest = waitrequest_q;

  assign addr_idx = 32'(s0_address);
  assign mapped   = (addr_idx <= AddrErrcount);
  assign rd_acc   = s0_read & ~waitrequest_q;
  assign wr_acc   = s0_write & ~waitrequest_q;
  // A simultaneous read+write performs the read and drops the write.
  assign collide  = rd_acc & wr_acc;
  assign wr_do    = wr_acc & ~s0_read;
  assign err_evt  = (rd_acc | wr_acc) & (~mapped | collide);

  always_comb begin
    rd_data = UnmappedData;
    case (addr_idx)
      AddrId:       rd_data = ID_VALUE;
      AddrScratch:  rd_data = scratch_q;
      AddrControl:  rd_data = {24'h0, ctrl_q};
      AddrStatus:   rd_data = status_q;
      AddrCycles:   rd_data = cycles_q;
      AddrWrcount:  rd_data = wrcount_q;
      AddrErrcount: rd_data = errcount_q;
      default:      rd_data = UnmappedData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q  <= '0;
      ctrl_q     <= '0;
      status_q   <= '0;
      cycles_q   <= '0;
      wrcount_q  <= '0;
      errcount_q <= '0;
    end else begin
      status_q <= status_in;
      cycles_q <= cycles_q + 32'd1;
      if (wr_do && addr_idx == AddrScratch) begin
        scratch_q <= merge_bytes(scratch_q, s0_writedata, s0_byteenable);
      end
      if (wr_do && addr_idx == AddrControl && s0_byteenable[0]) begin
        ctrl_q <= s0_writedata[7:0];
      end
      if (wr_do && addr_idx == AddrWrcount) begin
        wrcount_q <= '0;
      end else if (wr_do) begin
        wrcount_q <= wrcount_q + 32'd1;
      end
      // Clear takes precedence over a concurrent error increment.
      if (wr_do && addr_idx == AddrErrcount) begin
        errcount_q <= '0;
      end else if (err_evt && errcount_q != '1) begin
        errcount_q <= errcount_q + 32'd1;
      end
    end
  end

  always_comb begin
    pipe_in = '0;
    if (rd_acc) begin
      pipe_in.valid    = 1'b1;
      pipe_in.is_write = 1'b0;
      pipe_in.resp     = (mapped && !collide) ? RespOkay : RespSlvErr;
      pipe_in.data     = rd_data;
    end
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
    else if (wr_acc) begin
      pipe_in.valid    = 1'b1;
      pipe_in.is_write = 1'b1;
      pipe_in.resp     = mapped ? RespOkay : RespSlvErr;
    end
`endif
  end

  xcvr_csr_resp_pipe #(
    .Depth(READ_LATENCY)
  ) u_resp_pipe (
    .clk_i  (clk),
    .reset_i(reset),
    .entry_i(pipe_in),
    .entry_o(pipe_out)
  );

  assign s0_readdatavalid = pipe_out.valid & ~pipe_out.is_write;
  assign s0_readdata      = s0_readdatavalid ? pipe_out.data : '0;
  assign ctrl_out         = ctrl_q;

`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
  assign s0_writeresponsevalid = pipe_out.valid & pipe_out.is_write;
  assign s0_response           = pipe_out.valid ? pipe_out.resp : RespOkay;
`else
  logic unused_resp;
  assign unused_resp = ^pipe_out.resp;
`endif

endmodule

// File: tb/tb_xcvr_csr_agent.sv
// Self-checking bench for xcvr_csr_agent: directed scenarios plus randomized traffic checked
// against a behavioural register/response model.
module tb_xcvr_csr_agent;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_waitrequest;
  logic [31:0] s0_readdata;
  logic        s0_readdatavalid;
  logic [31:0] s0_writedata;
  logic [3:0]  s0_address;
  logic        s0_write;
  logic        s0_read;
  logic [3:0]  s0_byteenable;
  logic [31:0] status_in;
  logic [7:0]  ctrl_out;
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
  logic        s0_writeresponsevalid;
  logic [1:0]  s0_response;
`endif

  always #5 clk = ~clk;

  xcvr_csr_agent dut (
    .clk                  (clk),
    .reset                (reset),
    .s0_waitrequest       (s0_waitrequest),
    .s0_readdata          (s0_readdata),
    .s0_readdatavalid     (s0_readdatavalid),
    .s0_writedata         (s0_writedata),
    .s0_address           (s0_address),
    .s0_write             (s0_write),
    .s0_read              (s0_read),
    .s0_byteenable        (s0_byteenable),
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
    .s0_writeresponsevalid(s0_writeresponsevalid),
    .s0_response          (s0_response),
`endif
    .status_in            (status_in),
    .ctrl_out             (ctrl_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: register contents plus a list of responses with the cycle they are due.
  typedef struct {
    int          due;
    bit          is_write;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        expq[$];
  int          cyc = 0;
  int          since_reset = 0;
  logic [31:0] m_scratch, m_status, m_cycles, m_wrcount, m_errcount;
  logic [7:0]  m_ctrl;
  logic        exp_wait, exp_valid, exp_wrvalid;
  logic [31:0] exp_data;
  logic [1:0]  exp_resp;

  function automatic logic [31:0] model_read(int a);
    case (a)
      0:       return 32'hF7E1_0001;
      1:       return m_scratch;
      2:       return {24'h0, m_ctrl};
      3:       return m_status;
      4:       return m_cycles;
      5:       return m_wrcount;
      6:       return m_errcount;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic drive(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                       input logic [3:0] be);
    s0_read       = rd;
    s0_write      = wr;
    s0_address    = 4'(a);
    s0_writedata  = wd;
    s0_byteenable = be;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 4'h0);
  endtask

  // Advance one clock, update the model from the inputs present at that edge, and publish the
  // outputs expected just after it.
  task automatic step();
    int   a;
    bit   acc_rd, acc_wr, drop, unm;
    exp_t e;
    a      = int'(s0_address);
    acc_rd = !reset && s0_read && since_reset >= 4;
    acc_wr = !reset && s0_write && since_reset >= 4;
    @(posedge clk);
    cyc++;
    if (reset) begin
      since_reset = 0;
      m_scratch = 0; m_ctrl = 0; m_status = 0; m_cycles = 0; m_wrcount = 0; m_errcount = 0;
      expq.delete();
    end else begin
      unm  = a > 6;
      drop = acc_rd && acc_wr;
      if (acc_rd) begin
        e.due = cyc + Lat - 1; e.is_write = 0; e.data = model_read(a);
        e.resp = (unm || drop) ? 2'b10 : 2'b00;
        expq.push_back(e);
      end
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
      else if (acc_wr) begin
        e.due = cyc + Lat - 1; e.is_write = 1; e.data = 0; e.resp = unm ? 2'b10 : 2'b00;
        expq.push_back(e);
      end
`endif
      if (acc_wr && !drop) begin
        if (a == 1) begin
          for (int i = 0; i < 4; i++)
            if (s0_byteenable[i]) m_scratch[8*i +: 8] = s0_writedata[8*i +: 8];
        end
        if (a == 2 && s0_byteenable[0]) m_ctrl = s0_writedata[7:0];
        if (a == 5) m_wrcount = 0;
        else m_wrcount = m_wrcount + 1;
      end
      if (acc_wr && !drop && a == 6) m_errcount = 0;
      else if ((acc_rd || acc_wr) && (unm || drop) && m_errcount != 32'hFFFF_FFFF)
        m_errcount = m_errcount + 1;
      m_status = status_in;
      m_cycles = m_cycles + 1;
      if (since_reset < 4) since_reset++;
    end
    #1;
    exp_wait = (since_reset < 4);
    exp_valid = 0; exp_wrvalid = 0; exp_data = 0; exp_resp = 0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      exp_valid   = !e.is_write;
      exp_wrvalid = e.is_write;
      exp_data    = e.is_write ? 32'h0 : e.data;
      exp_resp    = e.resp;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && s0_waitrequest !== 1'b0; i++) step();
    vectors++;
    if (s0_waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_timeout: waitrequest=%b required 0", s0_waitrequest);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1; idle(); status_in = 0;
    step(); step();
    vectors += 4;
    if (s0_waitrequest !== 1'b1) begin
      miscompares++; $display("FAIL rst_wait: got %b required 1", s0_waitrequest);
    end
    if (s0_readdatavalid !== 1'b0) begin
      miscompares++; $display("FAIL rst_valid: got %b required 0", s0_readdatavalid);
    end
    if (s0_readdata !== 32'h0) begin
      miscompares++; $display("FAIL rst_data: got %h required 0", s0_readdata);
    end
    if (ctrl_out !== 8'h0) begin
      miscompares++; $display("FAIL rst_ctrl: got %h required 0", ctrl_out);
    end
    reset = 0;
    drive(1, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10 && s0_waitrequest !== 1'b0; i++) begin
      n++;
      step();
    end
    vectors++;
    if (n !== 4) begin
      miscompares++; $display("FAIL init_cycles: got %0d required 4", n);
    end
    step();
    idle();
    vectors++;
    if (s0_readdatavalid !== 1'b0) begin
      miscompares++; $display("FAIL id_early: valid=%b required 0", s0_readdatavalid);
    end
    step();
    vectors++;
    if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'hF7E1_0001) begin
      miscompares++;
      $display("FAIL id_read: valid=%b data=%h required 1/f7e10001", s0_readdatavalid,
               s0_readdata);
    end
  endtask

  task automatic test_byte_write();
    drive(0, 1, 1, 32'hAABB_CCDD, 4'b0101); step();
    drive(1, 0, 1, 0, 0); step();
    idle(); step();
    vectors += 2;
    if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'h00BB_00DD) begin
      miscompares++;
      $display("FAIL byte_lanes: valid=%b data=%h required 1/00bb00dd", s0_readdatavalid,
               s0_readdata);
    end
    if (ctrl_out !== 8'h00) begin
      miscompares++; $display("FAIL ctrl_untouched: got %h required 00", ctrl_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    want[0] = 32'hF7E1_0001; want[1] = 32'h00BB_00DD; want[2] = 32'h5;
    status_in = 5; step();
    drive(1, 0, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (s0_readdatavalid !== 1'b1 || s0_readdata !== want[k] || s0_readdata !== exp_data) begin
        miscompares++;
        $display("FAIL b2b_%0d: valid=%b data=%h required 1/%h", k, s0_readdatavalid,
                 s0_readdata, want[k]);
      end
      if (k == 0) drive(1, 0, 3, 0, 0);
      else idle();
      step();
    end
    vectors++;
    if (s0_readdatavalid !== 1'b0 || s0_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_tail: valid=%b data=%h required 0/0", s0_readdatavalid, s0_readdata);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] want [4];
    reset = 1; idle(); step(); reset = 0; wait_ready();
    want[0] = 32'hDEAD_BEEF; want[1] = 32'h0; want[2] = 32'h2; want[3] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1, 0, 9, 0, 0);
        1: drive(1, 1, 1, 32'h1111_2222, 4'hF);
        2: drive(1, 0, 6, 0, 0);
        default: drive(1, 0, 1, 0, 0);
      endcase
      step(); idle(); step();
      vectors++;
      if (s0_readdatavalid !== 1'b1 || s0_readdata !== want[k]) begin
        miscompares++;
        $display("FAIL unmapped_%0d: valid=%b data=%h required 1/%h", k, s0_readdatavalid,
                 s0_readdata, want[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 1, 32'h1234_5678, 4'hF); step();
    drive(0, 1, 2, 32'h0000_005A, 4'h1); step();
    vectors++;
    if (ctrl_out !== 8'h5A) begin
      miscompares++; $display("FAIL ctrl_write: got %h required 5a", ctrl_out);
    end
    drive(1, 0, 1, 0, 0); step();
    idle(); reset = 1; step();
    vectors += 3;
    if (s0_readdatavalid !== 1'b0 || s0_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_discard: valid=%b data=%h required 0/0", s0_readdatavalid, s0_readdata);
    end
    if (ctrl_out !== 8'h0) begin
      miscompares++; $display("FAIL mid_ctrl: got %h required 0", ctrl_out);
    end
    if (s0_waitrequest !== 1'b1) begin
      miscompares++; $display("FAIL mid_wait: got %b required 1", s0_waitrequest);
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (s0_readdatavalid !== 1'b0) begin
        miscompares++; $display("FAIL mid_quiet_%0d: valid=%b required 0", i, s0_readdatavalid);
      end
    end
    wait_ready();
    drive(1, 0, 1, 0, 0); step(); idle(); step();
    vectors++;
    if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_scratch: valid=%b data=%h required 1/0", s0_readdatavalid, s0_readdata);
    end
  endtask

`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
  task automatic test_write_response();
    drive(0, 1, 8, 32'h1, 4'hF); step(); idle(); step();
    vectors++;
    if (s0_writeresponsevalid !== 1'b1 || s0_response !== 2'b10 || s0_readdatavalid !== 1'b0)
    begin
      miscompares++;
      $display("FAIL wr_resp: wrvalid=%b resp=%b rdvalid=%b required 1/10/0",
               s0_writeresponsevalid, s0_response, s0_readdatavalid);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      status_in = $urandom();
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6)),
            $urandom(), 4'($urandom_range(0, 15)));
      step();
      vectors++;
      if (s0_waitrequest !== exp_wait || s0_readdatavalid !== exp_valid ||
          s0_readdata !== exp_data || ctrl_out !== m_ctrl) begin
        miscompares++;
        $display("FAIL rand_%0d: wait=%b valid=%b data=%h ctrl=%h required %b/%b/%h/%h", n,
                 s0_waitrequest, s0_readdatavalid, s0_readdata, ctrl_out, exp_wait, exp_valid,
                 exp_data, m_ctrl);
      end
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
      vectors++;
      if (s0_writeresponsevalid !== exp_wrvalid || s0_response !== exp_resp) begin
        miscompares++;
        $display("FAIL rand_resp_%0d: wrvalid=%b resp=%b required %b/%b", n,
                 s0_writeresponsevalid, s0_response, exp_wrvalid, exp_resp);
      end
`endif
    end
    reset = 0; idle();
  endtask

  initial begin
    reset = 1; status_in = 0; idle();
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
`ifdef XCVR_CSR_AGENT_WRITERESPONSE_EN
    test_write_response();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
